// File: rtl/m_bus_demultiplexor1_4_if.sv
// Bus bundle between the core data port, the 1:4 request demultiplexor and its four targets.
interface m_bus_demultiplexor1_4_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_we;
  logic        o_rsp_valid;
  logic [31:0] o_rdata;
  logic        o_rsp_err;
  logic [3:0]  o_t_valid;
  logic [3:0]  i_t_ready;
  logic [31:0] o_t_addr;
  logic [31:0] o_t_wdata;
  logic        o_t_we;
  logic [3:0]  i_t_rsp_valid;
  logic [31:0] i_t_rdata0;
  logic [31:0] i_t_rdata1;
  logic [31:0] i_t_rdata2;
  logic [31:0] i_t_rdata3;

  // Demultiplexor side.
  modport slave (
    input  i_req_valid, i_addr, i_wdata, i_we,
    input  i_t_ready, i_t_rsp_valid, i_t_rdata0, i_t_rdata1, i_t_rdata2, i_t_rdata3,
    output o_req_ready, o_rsp_valid, o_rdata, o_rsp_err,
    output o_t_valid, o_t_addr, o_t_wdata, o_t_we
  );

  // Environment side: core data port plus the four targets.
  modport master (
    output i_req_valid, i_addr, i_wdata, i_we,
    output i_t_ready, i_t_rsp_valid, i_t_rdata0, i_t_rdata1, i_t_rdata2, i_t_rdata3,
    input  o_req_ready, o_rsp_valid, o_rdata, o_rsp_err,
    input  o_t_valid, o_t_addr, o_t_wdata, o_t_we
  );
endinterface

// File: rtl/m_bus_demultiplexor1_4.sv
// Routes one load/store at a time to one of four targets chosen by two address bits.
// Define M_BUS_DEMUX_TIMEOUT_EN to add the TIMEOUT-cycle error completion path.
module m_bus_demultiplexor1_4 #(
  parameter int unsigned SEL_LSB = 30,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                     i_clk,
  input logic                     i_reset,
  m_bus_demultiplexor1_4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must lie in 2..65535");
  end

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] t_addr_q, t_addr_d;
  logic [31:0] t_wdata_q, t_wdata_d;
  logic        t_we_q, t_we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [3:0]  t_valid_q, t_valid_d;

  logic [31:0] sel_rdata_s;
  logic        ready_hit_s;
  logic        rsp_hit_s;
  logic        timeout_s;

  assign ready_hit_s = bus.i_t_ready[sel_q];
  assign rsp_hit_s   = bus.i_t_rsp_valid[sel_q];

`ifdef M_BUS_DEMUX_TIMEOUT_EN
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);
  logic [15:0] count_q, count_d;

  assign timeout_s = (count_q == LAST_CNT);

  // Counter restarts on every state change and advances while waiting in REQ or WAIT.
  always_comb begin
    if (state_d != state_q) begin
      count_d = 16'd0;
    end else if (state_q == REQ || state_q == WAIT) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Response data of the currently selected target.
  always_comb begin
    case (sel_q)
      2'd0:    sel_rdata_s = bus.i_t_rdata0;
      2'd1:    sel_rdata_s = bus.i_t_rdata1;
      2'd2:    sel_rdata_s = bus.i_t_rdata2;
      2'd3:    sel_rdata_s = bus.i_t_rdata3;
      default: sel_rdata_s = 32'd0;
    endcase
  end

  // State register and all captured/registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      t_addr_q    <= 32'd0;
      t_wdata_q   <= 32'd0;
      t_we_q      <= 1'b0;
      rdata_q     <= 32'd0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      t_valid_q   <= 4'b0000;
`ifdef M_BUS_DEMUX_TIMEOUT_EN
      count_q     <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      t_addr_q    <= t_addr_d;
      t_wdata_q   <= t_wdata_d;
      t_we_q      <= t_we_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      t_valid_q   <= t_valid_d;
`ifdef M_BUS_DEMUX_TIMEOUT_EN
      count_q     <= count_d;
`endif
    end
  end

  // Next state and data capture; a completing event in the same cycle beats the timeout.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    t_addr_d  = t_addr_q;
    t_wdata_d = t_wdata_q;
    t_we_d    = t_we_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          state_d   = REQ;
          sel_d     = bus.i_addr[SEL_LSB+1:SEL_LSB];
          t_addr_d  = bus.i_addr;
          t_wdata_d = bus.i_wdata;
          t_we_d    = bus.i_we;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (ready_hit_s) begin
          state_d = WAIT;
        end else if (timeout_s) begin
          state_d   = RESP;
          rdata_d   = 32'd0;
          rsp_err_d = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (rsp_hit_s) begin
          state_d   = RESP;
          rdata_d   = sel_rdata_s;
          rsp_err_d = 1'b0;
        end else if (timeout_s) begin
          state_d   = RESP;
          rdata_d   = 32'd0;
          rsp_err_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they leave the block registered.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    if (state_d == REQ) begin
      t_valid_d = 4'b0001 << sel_d;
    end else begin
      t_valid_d = 4'b0000;
    end
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_t_valid   = t_valid_q;
  assign bus.o_t_addr    = t_addr_q;
  assign bus.o_t_wdata   = t_wdata_q;
  assign bus.o_t_we      = t_we_q;

endmodule

// File: tb/tb_m_bus_demultiplexor1_4.sv
// Bench for m_bus_demultiplexor1_4: directed and random transactions against a cycle-count model,
// responses checked by a queue-based monitor.
module tb_m_bus_demultiplexor1_4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;

  m_bus_demultiplexor1_4_if bus ();

  m_bus_demultiplexor1_4 #(.SEL_LSB(30), .TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected {err, rdata}: a timeout fires once a wait phase reaches TO cycles.
  function automatic logic [32:0] model(input int rd, input int rs, input logic [31:0] rdata);
`ifdef M_BUS_DEMUX_TIMEOUT_EN
    if (rd >= TO || rs >= TO) return {1'b1, 32'h0};
`endif
    return {1'b0, rdata};
  endfunction

  // Cycle index (0 = first cycle after acceptance) in which o_rsp_valid is high.
  function automatic int resp_cycle(input int rd, input int rs);
`ifdef M_BUS_DEMUX_TIMEOUT_EN
    if (rd >= TO) return TO;
    if (rs >= TO) return rd + 1 + TO;
`endif
    return rd + rs + 2;
  endfunction

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.o_rsp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: actual rdata=%h err=%b required no response",
                 bus.o_rdata, bus.o_rsp_err);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.o_rsp_err, bus.o_rdata} !== mon_exp) begin
          bad++;
          $display("FAIL rsp_data: actual err=%b rdata=%h required err=%b rdata=%h",
                   bus.o_rsp_err, bus.o_rdata, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic set_rdata(input logic [1:0] sel, input logic [31:0] rdata);
    bus.i_t_rdata0 = (sel == 2'd0) ? rdata : $urandom;
    bus.i_t_rdata1 = (sel == 2'd1) ? rdata : $urandom;
    bus.i_t_rdata2 = (sel == 2'd2) ? rdata : $urandom;
    bus.i_t_rdata3 = (sel == 2'd3) ? rdata : $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.o_req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_idle", {31'd0, bus.o_req_ready}, 32'd1);
  endtask

  // Target selected by addr acks after rd REQ cycles and responds rs WAIT cycles later;
  // the other targets toggle ready/rsp_valid randomly and must be ignored.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input int rd, input int rs, input logic [31:0] rdata);
    logic [1:0] sel;
    logic [3:0] onehot;
    int rc, last, req_last;
    sel = addr[31:30];
    onehot = 4'b0001 << sel;
    rc = resp_cycle(rd, rs);
    last = rd + rs + 6;
    req_last = rd;
`ifdef M_BUS_DEMUX_TIMEOUT_EN
    if (req_last > TO - 1) req_last = TO - 1;
`endif
    wait_idle();
    exp_q.push_back(model(rd, rs, rdata));
    bus.i_req_valid = 1'b1;
    bus.i_addr = addr;
    bus.i_wdata = wdata;
    bus.i_we = we;
    tick();
    bus.i_req_valid = 1'b0;
    bus.i_addr = $urandom;
    bus.i_wdata = $urandom;
    bus.i_we = ~we;
    for (int k = 0; k <= last; k++) begin
      bus.i_t_ready = (4'($urandom) & ~onehot) | ((k == rd) ? onehot : 4'b0000);
      bus.i_t_rsp_valid = (4'($urandom) & ~onehot) | ((k == rd + 1 + rs) ? onehot : 4'b0000);
      set_rdata(sel, rdata);
      @(negedge clk);
      check("t_valid", {28'd0, bus.o_t_valid}, (k <= req_last) ? {28'd0, onehot} : 32'd0);
      check("rsp_valid_timing", {31'd0, bus.o_rsp_valid}, (k == rc) ? 32'd1 : 32'd0);
      if (k == 0) begin
        check("t_addr_held", bus.o_t_addr, addr);
        check("t_wdata_held", bus.o_t_wdata, wdata);
        check("t_we_held", {31'd0, bus.o_t_we}, {31'd0, we});
      end
      tick();
    end
    bus.i_t_ready = 4'b0000;
    bus.i_t_rsp_valid = 4'b0000;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_addr = 32'd0;
    bus.i_wdata = 32'd0;
    bus.i_we = 1'b0;
    bus.i_t_ready = 4'b0000;
    bus.i_t_rsp_valid = 4'b0000;
    set_rdata(2'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus.o_req_ready}, 32'd1);
    check("rst_t_valid", {28'd0, bus.o_t_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    check("rst_rdata", bus.o_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, bus.o_rsp_err}, 32'd0);
    tick();

    // Reset abandons a sel=0 load sitting in WAIT; no response may follow.
    wait_idle();
    bus.i_req_valid = 1'b1;
    bus.i_addr = 32'h0000_0040;
    bus.i_we = 1'b0;
    tick();
    bus.i_req_valid = 1'b0;
    bus.i_t_ready = 4'b0001;
    tick();
    bus.i_t_ready = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, bus.o_req_ready}, 32'd1);
    check("midrst_t_valid", {28'd0, bus.o_t_valid}, 32'd0);
    check("midrst_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    tick();
    bus.i_t_rsp_valid = 4'b0001;
    bus.i_t_rdata0 = 32'h5555_AAAA;
    tick();
    bus.i_t_rsp_valid = 4'b0000;
    repeat (3) tick();
    check("midrst_rdata", bus.o_rdata, 32'd0);

    run_txn(32'h4000_0010, 32'h0000_0000, 1'b0, 0, 0, 32'hCAFE_F00D);
    run_txn(32'hC000_0004, 32'h1234_5678, 1'b1, 5, 1, 32'h0BAD_CAFE);
    run_txn(32'h8000_0020, 32'h0, 1'b0, TO + 3, 1, 32'hDEAD_BEEF);
    run_txn(32'h8000_0024, 32'h0, 1'b0, 0, TO - 1, 32'h1111_2222);
    run_txn(32'h0000_0100, 32'h0, 1'b0, TO - 1, 0, 32'h3333_4444);
    run_txn(32'h4000_0200, 32'h0, 1'b1, 0, TO, 32'h5555_6666);
    for (int i = 0; i < 25; i++) begin
      run_txn($urandom, $urandom, 1'($urandom), $urandom_range(0, 10),
              $urandom_range(0, 10), $urandom);
    end

    repeat (5) tick();
    check("pending_rsp", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_bus_demultiplexor1_4.md
Name: m_bus_demultiplexor1_4

Overview:
- Routes one upstream load/store request from the CPU data-memory port to one of four downstream targets (RAM, I/O, timer, spare).
- Target is chosen by two address bits; the target's response is returned upstream.
- This is the distributing end of the 4:1 data-return multiplexing already used in the datapath.
- One transaction in flight at a time. Sits between core data port and memory/peripheral targets.

Parameters:
- SEL_LSB, 30, low bit of the 2-bit target select field; sel = i_addr[SEL_LSB+1:SEL_LSB]
- TIMEOUT, 255, cycles allowed in REQ+WAIT before error completion; legal range 2..65535

Ports:
- i_clk  input  1  clock, rising edge
- i_reset  input  1  synchronous, active-high reset
- i_req_valid  input  1  upstream request valid
- o_req_ready  output  1  upstream request accepted when high with i_req_valid
- i_addr  input  32  request address
- i_wdata  input  32  write data
- i_we  input  1  1 = store, 0 = load
- o_rsp_valid  output  1  one-cycle response strobe
- o_rdata  output  32  response data
- o_rsp_err  output  1  response is a timeout error, qualified by o_rsp_valid
- o_t_valid  output  4  one-hot request valid per target
- i_t_ready  input  4  per-target request accept
- o_t_addr  output  32  captured address, shared by all targets
- o_t_wdata  output  32  captured write data, shared
- o_t_we  output  1  captured write enable, shared
- i_t_rsp_valid  input  4  per-target response valid
- i_t_rdata0, i_t_rdata1, i_t_rdata2, i_t_rdata3  input  32 each  per-target response data

Behaviour:
- Single clock i_clk; i_reset synchronous, active-high. All state updates on the rising edge.
- Reset values:
  - state = IDLE; o_req_ready = 1 (decoded from IDLE).
  - o_t_valid = 0, o_rsp_valid = 0, o_rsp_err = 0.
  - o_rdata = 0, o_t_addr = 0, o_t_wdata = 0, o_t_we = 0, sel = 0, timeout count = 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - o_req_ready = 1.
  - On i_req_valid: capture i_addr, i_wdata, i_we and sel into registers; count <= 0; go to REQ.
- REQ:
  - o_t_valid = 1 << sel; all other bits 0.
  - On i_t_ready[sel]: go to WAIT, count <= 0.
  - i_t_ready bits of unselected targets are ignored.
- WAIT:
  - o_t_valid = 0.
  - On i_t_rsp_valid[sel]: capture i_t_rdata<sel> into o_rdata, o_rsp_err <= 0, go to RESP.
  - Responses from unselected targets are ignored.
- RESP:
  - o_rsp_valid = 1 for exactly one cycle; go to IDLE.
  - o_req_ready = 0 in this state, so back-to-back accepts are separated by at least 4 cycles.
- Responses are sampled only in WAIT. A target asserting rsp_valid in the same cycle as ready is not captured.
- Minimum latency: accept edge at T, REQ at T+1 with ready, WAIT at T+2 with rsp_valid, o_rsp_valid high during T+3.
- Held values:
  - o_t_addr, o_t_wdata and o_t_we hold captured values from acceptance until the next acceptance.
  - o_rdata and o_rsp_err hold until the next capture.
- Stores complete the same way as loads; o_rdata carries whatever the target drives.
- Timeout:
  - count increments each cycle spent in REQ or WAIT.
  - In a cycle where count == TIMEOUT-1 and no completing event occurs: o_rdata <= 0, o_rsp_err <= 1, go to RESP.
  - A completing event (ready in REQ, rsp_valid[sel] in WAIT) in that same cycle wins over the timeout.
- Late responses: a response arriving after a timeout, or while IDLE or RESP, is ignored.
- Reset mid-transaction: the transaction is abandoned; o_t_valid and o_rsp_valid are 0 from the cycle after the reset edge.

Optional Feature:
- Macro: M_BUS_DEMUX_TIMEOUT_EN.
- Defined: counter and timeout error path as described above.
- Undefined:
  - No counter is synthesized.
  - REQ and WAIT wait indefinitely.
  - o_rsp_err is constant 0.
  - TIMEOUT is ignored.

Test Plan:
- Reset held 2 cycles, then released -> o_req_ready=1; o_t_valid=4'b0000; o_rsp_valid=0; o_rdata=0.
- Load addr 32'h4000_0010 (sel=1), target 1 ready immediately, rsp next cycle with i_t_rdata1=32'hCAFE_F00D -> o_t_valid=4'b0010 for one cycle; o_rsp_valid at T+3; o_rdata=32'hCAFE_F00D; o_rsp_err=0.
- Store addr 32'hC000_0004 (sel=3), wdata 32'h1234_5678; i_t_ready[3] delayed 5 cycles; target 0 asserts rsp_valid meanwhile -> o_t_valid=4'b1000 held 6 cycles; o_t_wdata=32'h1234_5678, o_t_we=1; target 0 response ignored.
- With M_BUS_DEMUX_TIMEOUT_EN and TIMEOUT=8, target 2 never ready -> o_t_valid[2] high for 8 cycles; then o_rsp_valid=1, o_rsp_err=1, o_rdata=0. A later i_t_rsp_valid[2] produces no response.
- Timeout boundary, TIMEOUT=8: rsp_valid[sel] arrives in the WAIT cycle where count==7 -> normal response, o_rsp_err=0.
- i_reset asserted during WAIT of a sel=0 load -> next cycle state IDLE, o_req_ready=1, o_rsp_valid never pulses for that load.
